// File: rtl/io_port_responder.sv
// -----------------------------------------------------------------------------
// io_port_responder
//
// CPU-side I/O-space responder for the IOR/IOW path. Decodes a four-port
// block at IO_BASE and buffers device traffic in two small FIFOs:
//   RX FIFO : device -> CPU (read through RXDATA)
//   TX FIFO : CPU -> device (written through TXDATA)
// Every access completes in the single cycle in which iom_in is high.
//
// Port map (offset = addr_in[1:0]):
//   0 RXDATA  read pops RX head; read on empty returns 0, sets rx_underflow
//   1 STATUS  read-only; reading clears the sticky bits
//   2 TXDATA  write pushes TX; write on full drops data, sets tx_overflow
//   3 CTRL    write-only; data_in[0] flushes RX, data_in[1] flushes TX
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   iom_in, wen_in          I/O strobe, write enable (0 = write, 1 = read)
//   addr_in, data_in        CPU address and write data
//   data_out                CPU read data (combinational, 0 when not reading)
//   rx_data_in/valid/ready  device -> RX FIFO handshake
//   tx_data_out/valid/ready TX FIFO -> device handshake
// -----------------------------------------------------------------------------
module io_port_responder #(
    parameter int          DATA_W   = 16,
    parameter int          RX_DEPTH = 4,
    parameter int          TX_DEPTH = 4,
    parameter logic [15:0] IO_BASE  = 16'h00F0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iom_in,
    input  logic              wen_in,
    input  logic [15:0]       addr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] rx_data_in,
    input  logic              rx_valid_in,
    output logic              rx_ready_out,
    output logic [DATA_W-1:0] tx_data_out,
    output logic              tx_valid_out,
    input  logic              tx_ready_in
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);

    localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);

    localparam logic [1:0] OFF_RXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_TXDATA = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    // FIFO storage (not reset; contents are don't-care while empty)
    logic [DATA_W-1:0] r_rx_mem [RX_DEPTH];
    logic [DATA_W-1:0] r_tx_mem [TX_DEPTH];

    // FIFO occupancy state
    logic [RX_AW-1:0] r_rx_wp;
    logic [RX_AW-1:0] r_rx_rp;
    logic [RX_AW:0]   r_rx_cnt;
    logic [TX_AW-1:0] r_tx_wp;
    logic [TX_AW-1:0] r_tx_rp;
    logic [TX_AW:0]   r_tx_cnt;

    // Sticky error flags
    logic r_rx_uflow;
    logic r_tx_oflow;

    // Decode
    logic       w_sel;
    logic       w_rd;
    logic       w_wr;
    logic [1:0] w_off;

    // FIFO flags and transfer strobes
    logic w_rx_full;
    logic w_rx_empty;
    logic w_tx_full;
    logic w_tx_empty;
    logic w_rx_push;
    logic w_rx_pop;
    logic w_rx_uf_set;
    logic w_rx_flush;
    logic w_tx_push;
    logic w_tx_pop;
    logic w_tx_of_set;
    logic w_tx_flush;
    logic w_stat_rd;

    logic [2:0]  w_rx_cnt3;
    logic [2:0]  w_tx_cnt3;
    logic [15:0] w_status;

    assign w_sel = iom_in & (addr_in[15:2] == IO_BASE[15:2]);
    assign w_rd  = w_sel & wen_in;
    assign w_wr  = w_sel & ~wen_in;
    assign w_off = addr_in[1:0];

    assign w_rx_full  = (r_rx_cnt == RX_FULL_CNT);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == TX_FULL_CNT);
    assign w_tx_empty = (r_tx_cnt == '0);

    assign rx_ready_out = ~w_rx_full;
    assign tx_valid_out = ~w_tx_empty;
    // Gate with empty so the stale (unreset) storage never leaks out
    assign tx_data_out  = w_tx_empty ? '0 : r_tx_mem[r_tx_rp];

    // An RXDATA read on an empty FIFO is not a pop; it only flags underflow,
    // even if the device pushes in the same cycle.
    assign w_rx_push   = rx_valid_in & rx_ready_out;
    assign w_rx_pop    = w_rd & (w_off == OFF_RXDATA) & ~w_rx_empty;
    assign w_rx_uf_set = w_rd & (w_off == OFF_RXDATA) & w_rx_empty;
    assign w_rx_flush  = w_wr & (w_off == OFF_CTRL) & data_in[0];

    // Full is judged on registered state: a same-cycle device pop does not
    // make room for the CPU write.
    assign w_tx_push   = w_wr & (w_off == OFF_TXDATA) & ~w_tx_full;
    assign w_tx_of_set = w_wr & (w_off == OFF_TXDATA) & w_tx_full;
    assign w_tx_pop    = tx_valid_out & tx_ready_in;
    assign w_tx_flush  = w_wr & (w_off == OFF_CTRL) & data_in[1];

    assign w_stat_rd = w_rd & (w_off == OFF_STATUS);

    assign w_rx_cnt3 = 3'(r_rx_cnt);
    assign w_tx_cnt3 = 3'(r_tx_cnt);

    assign w_status = {1'b0, w_tx_cnt3, 1'b0, w_rx_cnt3, 2'b00,
                       r_tx_oflow, r_rx_uflow,
                       w_tx_full, w_tx_empty, w_rx_full, ~w_rx_empty};

    always_comb begin
        data_out = '0;
        if (w_rd) begin
            case (w_off)
                OFF_RXDATA: if (!w_rx_empty) data_out = r_rx_mem[r_rx_rp];
                OFF_STATUS: data_out = DATA_W'(w_status);
                default:    data_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= rx_data_in;
        if (w_tx_push) r_tx_mem[r_tx_wp] <= data_in;
    end

    // Flush has priority over any push/pop on the same FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else if (w_rx_flush) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else if (w_tx_flush) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // A set in the same cycle as a clearing STATUS read wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_uflow <= 1'b0;
            r_tx_oflow <= 1'b0;
        end else begin
            r_rx_uflow <= w_rx_uf_set | (r_rx_uflow & ~w_stat_rd);
            r_tx_oflow <= w_tx_of_set | (r_tx_oflow & ~w_stat_rd);
        end
    end

endmodule

// File: tb/tb_io_port_responder.sv
module tb_io_port_responder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iom_in;
    logic        wen_in;
    logic [15:0] addr_in;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [15:0] rx_data_in;
    logic        rx_valid_in;
    logic        rx_ready_out;
    logic [15:0] tx_data_out;
    logic        tx_valid_out;
    logic        tx_ready_in;

    always #5 clk = ~clk;

    io_port_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .iom_in       (iom_in),
        .wen_in       (wen_in),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .data_out     (data_out),
        .rx_data_in   (rx_data_in),
        .rx_valid_in  (rx_valid_in),
        .rx_ready_out (rx_ready_out),
        .tx_data_out  (tx_data_out),
        .tx_valid_out (tx_valid_out),
        .tx_ready_in  (tx_ready_in)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural reference: two bounded queues plus two sticky flags.
    logic [15:0] rx_q[$];
    logic [15:0] tx_q[$];
    bit          m_uf;
    bit          m_of;

    function automatic bit is_sel();
        return iom_in && (addr_in[15:2] == 14'h003C);
    endfunction

    function automatic logic [15:0] exp_status();
        logic [2:0] rc;
        logic [2:0] tc;
        rc = 3'(rx_q.size());
        tc = 3'(tx_q.size());
        return {1'b0, tc, 1'b0, rc, 2'b00, m_of, m_uf,
                tx_q.size() == DEPTH, tx_q.size() == 0,
                rx_q.size() == DEPTH, rx_q.size() != 0};
    endfunction

    function automatic logic [15:0] exp_dout();
        if (!(is_sel() && wen_in)) return 16'h0000;
        case (addr_in[1:0])
            2'd0:    return (rx_q.size() != 0) ? rx_q[0] : 16'h0000;
            2'd1:    return exp_status();
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        rx_q.delete();
        tx_q.delete();
        m_uf = 1'b0;
        m_of = 1'b0;
    endtask

    // Apply one clock edge of the access rules to the model, using the inputs
    // as they stand at the edge and the occupancy before it.
    task automatic model_edge();
        bit rd, wr, rx_full, rx_empty, tx_full;
        bit rx_push, rx_rd0, tx_wr2, tx_pop, stat_rd, fl_rx, fl_tx;
        logic [1:0] off;
        rd       = is_sel() && wen_in;
        wr       = is_sel() && !wen_in;
        off      = addr_in[1:0];
        rx_full  = (rx_q.size() == DEPTH);
        rx_empty = (rx_q.size() == 0);
        tx_full  = (tx_q.size() == DEPTH);
        rx_push  = rx_valid_in && !rx_full;
        rx_rd0   = rd && (off == 2'd0);
        stat_rd  = rd && (off == 2'd1);
        tx_wr2   = wr && (off == 2'd2);
        tx_pop   = (tx_q.size() != 0) && tx_ready_in;
        fl_rx    = wr && (off == 2'd3) && data_in[0];
        fl_tx    = wr && (off == 2'd3) && data_in[1];
        m_uf = (rx_rd0 && rx_empty) || (m_uf && !stat_rd);
        m_of = (tx_wr2 && tx_full) || (m_of && !stat_rd);
        if (fl_rx) rx_q.delete();
        else begin
            if (rx_rd0 && !rx_empty) void'(rx_q.pop_front());
            if (rx_push) rx_q.push_back(rx_data_in);
        end
        if (fl_tx) tx_q.delete();
        else begin
            if (tx_pop) void'(tx_q.pop_front());
            if (tx_wr2 && !tx_full) tx_q.push_back(data_in);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        iom_in      = 1'b0;
        wen_in      = 1'b1;
        addr_in     = 16'h0000;
        data_in     = 16'h0000;
        rx_valid_in = 1'b0;
        rx_data_in  = 16'h0000;
    endtask

    task automatic cpu(input bit wr, input logic [15:0] a, input logic [15:0] d);
        iom_in  = 1'b1;
        wen_in  = !wr;
        addr_in = a;
        data_in = d;
    endtask

    task automatic test_reset();
        idle();
        tx_ready_in = 1'b0;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        cpu(0, 16'h00F1, 16'h0000);
        #1;
        n_vec++;
        if (data_out !== 16'h0004) begin
            n_err++;
            $display("FAIL reset_status: got %h want %h", data_out, 16'h0004);
        end
        n_vec++;
        if (rx_ready_out !== 1'b1 || tx_valid_out !== 1'b0 || tx_data_out !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_handshake: rdy=%b vld=%b txd=%h want 1 0 0000",
                     rx_ready_out, tx_valid_out, tx_data_out);
        end
        tick();
        idle();
    endtask

    task automatic test_rx_fill_drain();
        logic [15:0] e;
        idle();
        for (int i = 0; i < 4; i++) begin
            rx_valid_in = 1'b1;
            rx_data_in  = 16'(16'h1111 * (i + 1));
            #1;
            tick();
        end
        idle();
        #1;
        n_vec++;
        if (rx_ready_out !== 1'b0) begin
            n_err++;
            $display("FAIL rx_full_ready: got %b want 0", rx_ready_out);
        end
        cpu(0, 16'h00F1, 16'h0000);
        #1;
        n_vec++;
        if (data_out !== 16'h0407) begin
            n_err++;
            $display("FAIL rx_full_status: got %h want %h", data_out, 16'h0407);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            cpu(0, 16'h00F0, 16'h0000);
            #1;
            e = (i < 4) ? 16'(16'h1111 * (i + 1)) : 16'h0000;
            n_vec++;
            if (data_out !== e) begin
                n_err++;
                $display("FAIL rx_read%0d: got %h want %h", i, data_out, e);
            end
            tick();
        end
        cpu(0, 16'h00F1, 16'h0000);
        #1;
        n_vec++;
        if (data_out !== 16'h0014) begin
            n_err++;
            $display("FAIL underflow_sticky: got %h want %h", data_out, 16'h0014);
        end
        tick();
        #1;
        n_vec++;
        if (data_out !== 16'h0004) begin
            n_err++;
            $display("FAIL underflow_cleared: got %h want %h", data_out, 16'h0004);
        end
        tick();
        idle();
    endtask

    task automatic test_tx_overflow();
        logic [15:0] e;
        idle();
        tx_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cpu(1, 16'h00F2, 16'(16'h00A0 + i));
            #1;
            tick();
        end
        cpu(0, 16'h00F1, 16'h0000);
        #1;
        n_vec++;
        if (data_out !== 16'h4028) begin
            n_err++;
            $display("FAIL tx_overflow_status: got %h want %h", data_out, 16'h4028);
        end
        tick();
        idle();
        tx_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            e = 16'(16'h00A0 + i);
            n_vec++;
            if (tx_valid_out !== 1'b1 || tx_data_out !== e) begin
                n_err++;
                $display("FAIL tx_drain%0d: vld=%b data=%h want 1 %h", i, tx_valid_out, tx_data_out, e);
            end
            tick();
        end
        #1;
        n_vec++;
        if (tx_valid_out !== 1'b0 || tx_data_out !== 16'h0000) begin
            n_err++;
            $display("FAIL tx_drained: vld=%b data=%h want 0 0000", tx_valid_out, tx_data_out);
        end
        tx_ready_in = 1'b0;
    endtask

    task automatic test_rx_simul();
        logic [15:0] v[3];
        idle();
        for (int i = 0; i < 3; i++) begin
            v[i] = 16'($urandom);
            rx_valid_in = 1'b1;
            rx_data_in  = v[i];
            #1;
            tick();
        end
        rx_valid_in = 1'b1;
        rx_data_in  = 16'h5555;
        cpu(0, 16'h00F0, 16'h0000);
        #1;
        n_vec++;
        if (data_out !== v[0]) begin
            n_err++;
            $display("FAIL simul_head: got %h want %h", data_out, v[0]);
        end
        tick();
        idle();
        cpu(0, 16'h00F1, 16'h0000);
        #1;
        n_vec++;
        if (data_out[10:8] !== 3'd3) begin
            n_err++;
            $display("FAIL simul_count: got %0d want 3", data_out[10:8]);
        end
        tick();
        idle();
    endtask

    task automatic test_flush();
        idle();
        cpu(1, 16'h00F3, 16'h0003);
        #1;
        tick();
        idle();
        tx_ready_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rx_valid_in = 1'b1;
            rx_data_in  = 16'(16'h0C00 + i);
            cpu(1, 16'h00F2, 16'(16'h0D00 + i));
            #1;
            tick();
        end
        rx_valid_in = 1'b1;
        rx_data_in  = 16'hBEEF;
        cpu(1, 16'h00F3, 16'h0003);
        #1;
        tick();
        idle();
        cpu(0, 16'h00F1, 16'h0000);
        #1;
        n_vec++;
        if (data_out !== 16'h0004) begin
            n_err++;
            $display("FAIL flush_status: got %h want %h", data_out, 16'h0004);
        end
        n_vec++;
        if (tx_valid_out !== 1'b0 || rx_ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL flush_handshake: vld=%b rdy=%b want 0 1", tx_valid_out, rx_ready_out);
        end
        tick();
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        tx_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_valid_in = 1'b1;
            rx_data_in  = 16'($urandom);
            if (i == 0) cpu(1, 16'h00F2, 16'h7777);
            else begin
                iom_in = 1'b0;
            end
            #1;
            tick();
        end
        iom_in = 1'b0;
        rx_valid_in = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (rx_ready_out !== 1'b1 || tx_valid_out !== 1'b0 ||
            tx_data_out !== 16'h0000 || data_out !== 16'h0000) begin
            n_err++;
            $display("FAIL async_reset: rdy=%b vld=%b txd=%h dout=%h want 1 0 0000 0000",
                     rx_ready_out, tx_valid_out, tx_data_out, data_out);
        end
        model_reset();
        #2;
        idle();
        rst_n = 1'b1;
        tick();
        cpu(0, 16'h00E1, 16'h0000);
        #1;
        n_vec++;
        if (data_out !== 16'h0000) begin
            n_err++;
            $display("FAIL offblock_read: got %h want 0000", data_out);
        end
        tick();
        cpu(1, 16'h00E2, 16'h1234);
        #1;
        tick();
        cpu(0, 16'h00F1, 16'h0000);
        #1;
        n_vec++;
        if (data_out !== 16'h0004 || tx_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL offblock_effect: status=%h vld=%b want 0004 0", data_out, tx_valid_out);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] e;
        int          r;
        for (int n = 0; n < 800; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = 16'(16'h00F0 + $urandom_range(0, 3));
            else if (r == 7) a = 16'(16'h00E0 + $urandom_range(0, 3));
            else if (r == 8) a = 16'(16'h00F4 + $urandom_range(0, 3));
            else             a = 16'($urandom);
            iom_in  = ($urandom_range(0, 3) != 0);
            wen_in  = $urandom_range(0, 1) != 0;
            addr_in = a;
            data_in = 16'($urandom);
            if (a[1:0] == 2'd3 && $urandom_range(0, 7) != 0) data_in[1:0] = 2'b00;
            rx_valid_in = $urandom_range(0, 1) != 0;
            rx_data_in  = 16'($urandom);
            tx_ready_in = ($urandom_range(0, 2) == 0);
            #1;
            e = exp_dout();
            n_vec++;
            if (data_out !== e) begin
                n_err++;
                $display("FAIL rand_dout@%0d: got %h want %h", n, data_out, e);
            end
            n_vec++;
            if (rx_ready_out !== (rx_q.size() != DEPTH)) begin
                n_err++;
                $display("FAIL rand_rx_ready@%0d: got %b want %b", n, rx_ready_out, rx_q.size() != DEPTH);
            end
            e = (tx_q.size() != 0) ? tx_q[0] : 16'h0000;
            n_vec++;
            if (tx_valid_out !== (tx_q.size() != 0) || tx_data_out !== e) begin
                n_err++;
                $display("FAIL rand_tx@%0d: vld=%b data=%h want %b %h",
                         n, tx_valid_out, tx_data_out, tx_q.size() != 0, e);
            end
            tick();
        end
        idle();
        tx_ready_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rx_fill_drain();
        test_tx_overflow();
        test_rx_simul();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
